mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 13 +
 rtl/mem_ctrl_mmio.sv | 60 ++++++
 rtl/mem_ctrl.sv | 119 +++++++++++
 tb/tb_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory/IO controller and its MMIO window.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] LED_OFF = 16'h0000;
  localparam logic [15:0] CYC_OFF = 16'h0004;

endpackage

// File: rtl/mem_ctrl_mmio.sv
// MMIO window registers: LED output register, free-running cycle counter and read mux.
module mmio_regs
  import mem_ctrl_pkg::*;
#(
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             led_we,
  input  logic [LED_W-1:0] led_wd,
  input  logic [15:0]      off,
  output logic [31:0]      rdata,
  output logic             hit,
  output logic [LED_W-1:0] led
);

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      cyc_q, cyc_d;

  // Next-state for the LED register and the wrapping cycle counter.
  always_comb begin
    led_d = led_q;
    if (led_we) led_d = led_wd;
    cyc_d = cyc_q + 32'd1;
  end

  // Register state; cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
      cyc_q <= '0;
    end else begin
      led_q <= led_d;
      cyc_q <= cyc_d;
    end
  end

  // Read mux over the window; unmapped offsets read as zero and report no hit.
  always_comb begin
    rdata = '0;
    hit   = 1'b0;
    case (off)
      LED_OFF: begin
        rdata = 32'(led_q);
        hit   = 1'b1;
      end
      CYC_OFF: begin
        rdata = cyc_q;
        hit   = 1'b1;
      end
      default: begin
        rdata = '0;
        hit   = 1'b0;
      end
    endcase
  end

  assign led = led_q;

endmodule

// File: rtl/mem_ctrl.sv
// Memory/IO controller: req/ready handshake with wait states, registered read
// data, single-cycle memory write strobe and a small MMIO window.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter int          LED_W       = 8,
  parameter logic [15:0] MMIO_BASE   = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      adr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             ready,
  output logic             bus_err,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic [LED_W-1:0] led
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;

  logic        accept, enter_resp;
  logic [31:0] dec_adr, mem_src_adr;
  logic        dec_we, dec_mmio, q_mmio;
  logic [31:0] mmio_rdata;
  logic        mmio_hit, led_we;

  assign accept     = (state_q == IDLE) && req;
  assign enter_resp = ((state_q == WAIT) && (cnt_q == 4'd1)) ||
                      (accept && (WAIT_CYCLES == 0));

  // With zero wait states the read is resolved on the accepting edge, so the
  // decode (and the memory address) must come straight from the core bus.
  assign dec_adr  = (state_q == IDLE) ? adr : adr_q;
  assign dec_we   = (state_q == IDLE) ? we  : we_q;
  assign dec_mmio = (dec_adr[31:16] == MMIO_BASE);
  assign q_mmio   = (adr_q[31:16] == MMIO_BASE);

  assign mem_src_adr = ((WAIT_CYCLES == 0) && (state_q == IDLE)) ? adr : adr_q;
  assign mem_a       = {mem_src_adr[31:2], 2'b00};
  assign mem_wd      = wd_q;
  assign mem_we      = (state_q == RESP) && we_q && !q_mmio;
  assign ready       = (state_q == RESP);
  assign bus_err     = (state_q == RESP) && q_mmio && !mmio_hit;
  assign led_we      = (state_q == RESP) && we_q && q_mmio && (adr_q[15:0] == LED_OFF);
  assign rd          = rd_q;

  mmio_regs #(.LED_W(LED_W)) u_mmio (
    .clk    (clk),
    .reset  (reset),
    .led_we (led_we),
    .led_wd (wd_q[LED_W-1:0]),
    .off    (dec_adr[15:0]),
    .rdata  (mmio_rdata),
    .hit    (mmio_hit),
    .led    (led)
  );

  // Access FSM and request latching; read data captured on the edge entering RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d   = adr;
          we_d    = we;
          wd_d    = wd;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp && !dec_we) rd_d = dec_mmio ? mmio_rdata : mem_rd;
  end

  // Controller state; reset aborts any in-flight access immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_mem_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req = 0, we = 0;
  logic [31:0] adr = 0, wd = 0;
  logic [31:0] rd, mem_a, mem_wd, mem_rd;
  logic        ready, bus_err, mem_we;
  logic [7:0]  led;

  logic        req0 = 0, we0 = 0;
  logic [31:0] adr0 = 0, wd0 = 0;
  logic [31:0] rd0, mem_a0, mem_wd0, mem_rd0;
  logic        ready0, bus_err0, mem_we0;
  logic [7:0]  led0;

  logic [31:0] mem  [0:255];
  logic [31:0] mem0 [0:255];
  logic        pl_en = 0, pl_en0 = 0;
  logic [7:0]  pl_idx = 0;
  logic [31:0] pl_dat = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.WAIT_CYCLES(W), .LED_W(8), .MMIO_BASE(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .adr(adr), .wd(wd),
    .rd(rd), .ready(ready), .bus_err(bus_err), .mem_we(mem_we),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd), .led(led)
  );

  mem_ctrl #(.WAIT_CYCLES(0), .LED_W(8), .MMIO_BASE(16'hFFFF)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .adr(adr0), .wd(wd0),
    .rd(rd0), .ready(ready0), .bus_err(bus_err0), .mem_we(mem_we0),
    .mem_a(mem_a0), .mem_wd(mem_wd0), .mem_rd(mem_rd0), .led(led0)
  );

  assign mem_rd  = mem[mem_a[9:2]];
  assign mem_rd0 = mem0[mem_a0[9:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[9:2]] <= mem_wd;
    else if (pl_en) mem[pl_idx] <= pl_dat;
  end

  always @(posedge clk) begin
    if (mem_we0) mem0[mem_a0[9:2]] <= mem_wd0;
    else if (pl_en0) mem0[pl_idx] <= pl_dat;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic sel0, input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    pl_idx = idx; pl_dat = d;
    if (sel0) pl_en0 = 1'b1; else pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0; pl_en0 = 1'b0;
  endtask

  // One access on the WAIT_CYCLES=2 instance; returns latency, read data, error and write-strobe stats.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r, output int lat, output logic err,
                        output int wec, output logic [31:0] wea);
    bit done;
    done = 0; r = 0; lat = 0; err = 0; wec = 0; wea = 0;
    @(negedge clk);
    req = 1; we = w; adr = a; wd = d;
    @(posedge clk);
    #1 req = 0; we = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin wec++; wea = mem_a; end
      if (ready) begin r = rd; err = bus_err; done = 1; end
    end
    @(negedge clk);
    if (mem_we) wec++;
    chk("ready_one_cycle", 32'(ready), 32'd0);
  endtask

  logic [31:0] r, wea, v1, v2;
  int          lat, wec, seen, cyc, t1, t2, extra_rdy, extra_we;
  logic        err;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state and memory preload while in reset
    #1;
    chk("rst_rd", rd, 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    preload(0, 8'd8,  32'hDEADBEEF);
    preload(0, 8'd32, 32'h11111111);
    preload(0, 8'd4,  32'h22222222);
    preload(0, 8'd17, 32'h00000000);
    preload(1, 8'd8,  32'hCAFEF00D);
    @(negedge clk);
    reset = 0;

    // Plain read with two wait states
    access(0, 32'h20, 0, r, lat, err, wec, wea);
    chk("rd_lat", 32'(lat), 32'(W + 1));
    chk("rd_data", r, 32'hDEADBEEF);
    chk("rd_no_we", 32'(wec), 32'd0);
    chk("rd_no_err", 32'(err), 32'd0);

    // Write then read back through a misaligned address
    access(1, 32'h44, 32'h12345678, r, lat, err, wec, wea);
    chk("wr_we_cycles", 32'(wec), 32'd1);
    chk("wr_mem_a", wea, 32'h44);
    chk("wr_mem", mem[17], 32'h12345678);
    access(0, 32'h46, 0, r, lat, err, wec, wea);
    chk("rb_data", r, 32'h12345678);

    // LED register write and read back
    access(1, 32'hFFFF0000, 32'h000000A5, r, lat, err, wec, wea);
    chk("led_val", 32'(led), 32'hA5);
    chk("led_no_we", 32'(wec), 32'd0);
    access(0, 32'hFFFF0000, 0, r, lat, err, wec, wea);
    chk("led_rb", r, 32'h000000A5);

    // Cycle counter read twice with req held high
    @(negedge clk);
    req = 1; we = 0; adr = 32'hFFFF0004;
    seen = 0; cyc = 0; t1 = 0; t2 = 0; v1 = 0; v2 = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk);
      cyc++;
      if (ready) begin
        if (seen == 0) begin v1 = rd; t1 = cyc; end
        else begin v2 = rd; t2 = cyc; req = 0; end
        seen++;
      end
    end
    req = 0;
    chk("cyc_seen", 32'(seen), 32'd2);
    chk("cyc_delta", v2 - v1, 32'(W + 2));
    chk("cyc_spacing", 32'(t2 - t1), 32'(W + 2));

    // Unmapped and read-only MMIO offsets
    access(1, 32'hFFFF0008, 32'h00000077, r, lat, err, wec, wea);
    chk("unm_wr_err", 32'(err), 32'd1);
    chk("unm_led", 32'(led), 32'hA5);
    chk("unm_no_we", 32'(wec), 32'd0);
    access(0, 32'hFFFF0010, 0, r, lat, err, wec, wea);
    chk("unm_rd_err", 32'(err), 32'd1);
    chk("unm_rd_zero", r, 32'd0);
    access(1, 32'hFFFF0004, 32'h0, r, lat, err, wec, wea);
    chk("cyc_wr_noerr", 32'(err), 32'd0);
    chk("cyc_wr_led", 32'(led), 32'hA5);

    // req glitch during WAIT must not start another access
    @(negedge clk);
    req = 1; we = 0; adr = 32'h20;
    @(posedge clk);
    #1 req = 0;
    @(negedge clk);
    req = 1; we = 1; adr = 32'h80; wd = 32'hBAD0BAD0;
    @(negedge clk);
    req = 0; we = 0;
    lat = 2; r = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready) begin r = rd; break; end
      @(negedge clk);
      lat++;
    end
    chk("gl_lat", 32'(lat), 32'(W + 1));
    chk("gl_data", r, 32'hDEADBEEF);
    extra_rdy = 0; extra_we = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) extra_rdy++;
      if (mem_we) extra_we++;
    end
    chk("gl_extra_ready", 32'(extra_rdy), 32'd0);
    chk("gl_extra_we", 32'(extra_we), 32'd0);
    chk("gl_mem", mem[32], 32'h11111111);

    // Reset in the middle of a write
    @(negedge clk);
    req = 1; we = 1; adr = 32'h10; wd = 32'h99999999;
    @(posedge clk);
    #1 req = 0; we = 0;
    @(negedge clk);
    reset = 1;
    #1;
    chk("mr_rd", rd, 32'd0);
    chk("mr_led", 32'(led), 32'd0);
    chk("mr_mem_we", 32'(mem_we), 32'd0);
    chk("mr_ready", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 0;
    extra_rdy = 0; extra_we = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) extra_rdy++;
      if (mem_we) extra_we++;
    end
    chk("mr_no_ready", 32'(extra_rdy), 32'd0);
    chk("mr_no_we", 32'(extra_we), 32'd0);
    chk("mr_mem", mem[4], 32'h22222222);
    chk("mr_led_after", 32'(led), 32'd0);

    // Zero wait states: ready one cycle after acceptance
    @(negedge clk);
    req0 = 1; we0 = 0; adr0 = 32'h20;
    @(posedge clk);
    #1 req0 = 0;
    @(negedge clk);
    chk("w0_rd_ready", 32'(ready0), 32'd1);
    chk("w0_rd_data", rd0, 32'hCAFEF00D);
    @(negedge clk);
    req0 = 1; we0 = 1; adr0 = 32'h30; wd0 = 32'h000055AA;
    @(posedge clk);
    #1 req0 = 0; we0 = 0;
    @(negedge clk);
    chk("w0_wr_ready", 32'(ready0), 32'd1);
    chk("w0_wr_we", 32'(mem_we0), 32'd1);
    chk("w0_wr_adr", mem_a0, 32'h30);
    @(negedge clk);
    chk("w0_ready_drop", 32'(ready0), 32'd0);
    chk("w0_mem", mem0[12], 32'h000055AA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
